// File: rtl/cheshire_xilinx_rst_pkg.sv
// cheshire_xilinx_rst_pkg: shared types and constants for the reset/boot sequencer
package cheshire_xilinx_rst_pkg;
  localparam int unsigned BootModeWidth = 2;
  typedef enum logic [1:0] {LOCK_WAIT, HOLD, RUN} rst_seq_state_e;
  typedef enum logic [1:0] {POR = 2'd0, BUTTON = 2'd1, LOCK_LOSS = 2'd2} rst_cause_e;
endpackage

// File: rtl/cheshire_xilinx_debounce.sv
// cheshire_xilinx_debounce: accepts a level change after DebounceCycles stable cycles; clk_i, rst_i, btn_i (synced) -> btn_o
module cheshire_xilinx_debounce #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o
);
  localparam int unsigned CntW = DebounceCycles > 1 ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  logic [CntW-1:0] cnt_q;
  logic db_q, diff, done;
  assign diff = btn_i != db_q;
  assign done = cnt_q == CntLast;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= (diff && !done) ? cnt_q + 1'b1 : '0;
      db_q  <= (diff && done) ? ~db_q : db_q;
    end
  end
  assign btn_o = db_q;
endmodule

// File: rtl/sync.sv
// sync: STAGES-deep flop synchronizer; ports clk_i, rst_i (sync, active-high), serial_i -> serial_o
module sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic serial_i,
  output logic serial_o
);
  logic [STAGES-1:0] reg_q;
  always_ff @(posedge clk_i) reg_q <= rst_i ? '0 : {reg_q[STAGES-2:0], serial_i};
  assign serial_o = reg_q[STAGES-1];
endmodule

// File: rtl/cheshire_xilinx_rst_boot_seq.sv
// cheshire_xilinx_rst_boot_seq: syncs/debounces board inputs, sequences SoC reset, latches straps; clk_i, rst_i, pll_locked_i, cpu_reset_btn_i, boot_mode_sw_i, test_mode_sw_i -> soc_rst_no, boot_mode_o, test_mode_o, ready_o, rst_cause_o
module cheshire_xilinx_rst_boot_seq
  import cheshire_xilinx_rst_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned HoldCycles     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pll_locked_i,
  input  logic                     cpu_reset_btn_i,
  input  logic [BootModeWidth-1:0] boot_mode_sw_i,
  input  logic                     test_mode_sw_i,
  output logic                     soc_rst_no,
  output logic [BootModeWidth-1:0] boot_mode_o,
  output logic                     test_mode_o,
  output logic                     ready_o,
  output logic [1:0]               rst_cause_o
);
  localparam int unsigned HoldW = HoldCycles > 1 ? $clog2(HoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
  logic lock_s, btn_s, btn_db, test_s, exit_req;
  logic [BootModeWidth-1:0] boot_s;
  sync #(.STAGES(SyncStages)) u_sync_lock (.clk_i, .rst_i, .serial_i(pll_locked_i), .serial_o(lock_s));
  sync #(.STAGES(SyncStages)) u_sync_btn (.clk_i, .rst_i, .serial_i(cpu_reset_btn_i), .serial_o(btn_s));
  sync #(.STAGES(SyncStages)) u_sync_test (.clk_i, .rst_i, .serial_i(test_mode_sw_i), .serial_o(test_s));
  for (genvar i = 0; i < BootModeWidth; i++) begin : g_boot
    sync #(.STAGES(SyncStages)) u_sync_boot (.clk_i, .rst_i, .serial_i(boot_mode_sw_i[i]), .serial_o(boot_s[i]));
  end
  cheshire_xilinx_debounce #(.DebounceCycles(DebounceCycles)) u_debounce (
    .clk_i, .rst_i, .btn_i(btn_s), .btn_o(btn_db)
  );
  rst_seq_state_e state_q, state_d;
  rst_cause_e cause_q, cause_d;
  logic [HoldW-1:0] cnt_q, cnt_d;
  logic [BootModeWidth-1:0] boot_q, boot_d;
  logic test_q, test_d, rst_n_q, ready_q;
  assign exit_req = !lock_s || btn_db;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    boot_d  = boot_q;
    test_d  = test_q;
    cnt_d   = state_q == HOLD ? cnt_q + HoldW'(cnt_q != HoldLast) : '0;
    if (state_q == LOCK_WAIT) begin
      state_d = exit_req ? LOCK_WAIT : HOLD;
    end else if (exit_req) begin
      state_d = LOCK_WAIT;
      cause_d = lock_s ? BUTTON : LOCK_LOSS;
    end else if (state_q == HOLD && cnt_q == HoldLast) begin
      state_d = RUN;
      boot_d  = boot_s;
      test_d  = test_s;
    end
  end
  // reset and ready are registered from the next state so they never glitch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOCK_WAIT;
      cause_q <= POR;
      cnt_q   <= '0;
      boot_q  <= '0;
      test_q  <= 1'b0;
      rst_n_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      boot_q  <= boot_d;
      test_q  <= test_d;
      rst_n_q <= state_d == RUN;
      ready_q <= state_d == RUN;
    end
  end
  assign soc_rst_no  = rst_n_q;
  assign ready_o     = ready_q;
  assign boot_mode_o = boot_q;
  assign test_mode_o = test_q;
  assign rst_cause_o = cause_q;
endmodule

// File: tb/tb_cheshire_xilinx_rst_boot_seq.sv
// tb_cheshire_xilinx_rst_boot_seq: directed and random checks against a run-length reference model
module tb_cheshire_xilinx_rst_boot_seq;
  localparam int D = 8;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rst = 1'b1, lock = 1'b0, btn = 1'b0, test = 1'b0;
  logic [1:0] boot = 2'b00;
  logic soc_rst_no, test_mode_o, ready_o;
  logic [1:0] boot_mode_o, rst_cause_o;
  int checks = 0, errors = 0, n, dropped;
  always #5 clk = ~clk;
  cheshire_xilinx_rst_boot_seq #(.SyncStages(2), .DebounceCycles(D), .HoldCycles(H)) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(lock), .cpu_reset_btn_i(btn),
    .boot_mode_sw_i(boot), .test_mode_sw_i(test), .soc_rst_no(soc_rst_no),
    .boot_mode_o(boot_mode_o), .test_mode_o(test_mode_o), .ready_o(ready_o),
    .rst_cause_o(rst_cause_o)
  );
  // model: two-stage delay per input, debounce as run length of disagreement,
  // and the SoC runs once the release condition has held for more than H cycles
  logic lk1, lk2, bt1, bt2, ts1, ts2, db, m_test;
  logic [1:0] bm1, bm2, m_boot, m_cause;
  int dr, r;
  task automatic model_clear();
    {lk1, lk2, bt1, bt2, ts1, ts2, db, m_test} = '0;
    {bm1, bm2, m_boot, m_cause} = '0;
    dr = 0;
    r = 0;
  endtask
  task automatic model_update();
    logic ok;
    int nr;
    if (rst) begin
      model_clear();
      return;
    end
    ok = lk2 && !db;
    nr = ok ? (r > H ? H + 1 : r + 1) : 0;
    if (r > 0 && !ok) m_cause = lk2 ? 2'd1 : 2'd2;
    if (nr == H + 1 && r == H) begin
      m_boot = bm2;
      m_test = ts2;
    end
    if (bt2 != db) begin
      dr++;
      if (dr == D) begin
        db = ~db;
        dr = 0;
      end
    end else dr = 0;
    r = nr;
    {lk2, lk1} = {lk1, lock};
    {bt2, bt1} = {bt1, btn};
    {ts2, ts1} = {ts1, test};
    bm2 = bm1;
    bm1 = boot;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("rst_n", 32'(soc_rst_no), 32'(r > H));
    chk("ready", 32'(ready_o), 32'(r > H));
    chk("boot", 32'(boot_mode_o), 32'(m_boot));
    chk("test", 32'(test_mode_o), 32'(m_test));
    chk("cause", 32'(rst_cause_o), 32'(m_cause));
  endtask
  task automatic wait_rstn(input logic v, input int lim, output int cnt);
    cnt = 0;
    while (soc_rst_no !== v && cnt < lim) begin
      step();
      cnt++;
    end
  endtask
  initial begin
    model_clear();
    repeat (3) step();
    chk("por_rst_n", 32'(soc_rst_no), 0);
    chk("por_cause", 32'(rst_cause_o), 0);
    rst = 1'b0;
    boot = 2'b10;
    test = 1'b1;
    dropped = 0;
    repeat (50) begin
      step();
      dropped |= int'(soc_rst_no);
    end
    chk("lockwait_hold", dropped, 0);
    lock = 1'b1;
    wait_rstn(1'b1, 100, n);
    chk("release_lat", n, 19);
    chk("pwr_boot", 32'(boot_mode_o), 2);
    chk("pwr_test", 32'(test_mode_o), 1);
    chk("pwr_cause", 32'(rst_cause_o), 0);
    for (int k = 0; k < 3; k++) begin
      dropped = 0;
      btn = 1'b1;
      repeat (k == 0 ? 1 : k == 1 ? 3 : 7) begin
        step();
        dropped |= int'(!soc_rst_no);
      end
      btn = 1'b0;
      repeat (20) begin
        step();
        dropped |= int'(!soc_rst_no);
      end
      chk("bounce", dropped, 0);
    end
    btn = 1'b1;
    wait_rstn(1'b0, 60, n);
    chk("btn_lat", n, 11);
    chk("btn_cause", 32'(rst_cause_o), 1);
    repeat (40 - n) step();
    btn = 1'b0;
    wait_rstn(1'b1, 100, n);
    chk("btn_rerelease", n, 27);
    boot = 2'b01;
    repeat (5) step();
    chk("run_frozen", 32'(boot_mode_o), 2);
    lock = 1'b0;
    wait_rstn(1'b0, 60, n);
    chk("lock_lat", n, 3);
    chk("lock_cause", 32'(rst_cause_o), 2);
    chk("lock_boot_old", 32'(boot_mode_o), 2);
    lock = 1'b1;
    wait_rstn(1'b1, 100, n);
    chk("relock_lat", n, 19);
    chk("relock_boot", 32'(boot_mode_o), 1);
    btn = 1'b1;
    repeat (8) step();
    lock = 1'b0;
    wait_rstn(1'b0, 60, n);
    chk("simul_lat", n, 3);
    chk("simul_cause", 32'(rst_cause_o), 2);
    btn = 1'b0;
    lock = 1'b1;
    wait_rstn(1'b1, 200, n);
    chk("simul_resume", 32'(soc_rst_no), 1);
    lock = 1'b0;
    repeat (5) step();
    lock = 1'b1;
    repeat (12) step();
    rst = 1'b1;
    step();
    chk("mid_rst_n", 32'(soc_rst_no), 0);
    chk("mid_ready", 32'(ready_o), 0);
    chk("mid_boot", 32'(boot_mode_o), 0);
    chk("mid_test", 32'(test_mode_o), 0);
    chk("mid_cause", 32'(rst_cause_o), 0);
    rst = 1'b0;
    wait_rstn(1'b1, 100, n);
    chk("mid_release", n, 19);
    chk("mid_boot_cap", 32'(boot_mode_o), 1);
    repeat (4000) begin
      if (lock ? $urandom_range(0, 199) == 0 : $urandom_range(0, 19) == 0) lock = ~lock;
      if (btn ? $urandom_range(0, 5) == 0 : $urandom_range(0, 59) == 0) btn = ~btn;
      if ($urandom_range(0, 39) == 0) boot = 2'($urandom);
      if ($urandom_range(0, 39) == 0) test = 1'($urandom);
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
